// File: rtl/ex_muldiv.sv
// RV32M iterative multiply/divide (radix-2 shift-add / restoring divide); optional MD_EARLY_OUT_EN shortcuts.
// Latency: md_done 33 cycles after start (1 for divide-by-zero/overflow and early-outs).
// Backpressure: stall_req holds the pipeline from the start cycle until DONE; flush aborts at once.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_reg1,
  input  logic [XLEN-1:0] md_reg2,
  input  logic            flush,
  output logic [XLEN-1:0] md_result,
  output logic            md_done,
  output logic            stall_req
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opd;
  logic [2:0]        op_q;
  logic              neg_a;
  logic              neg_r;

  logic            is_div, sgn1, sgn2, div_zero, div_ovf, early;
  logic [XLEN-1:0] mag1, mag2, special_res, early_res;

  assign is_div   = md_op[2];
  assign sgn1     = (md_op == 3'd1 || md_op == 3'd2 || md_op == 3'd4 || md_op == 3'd6) && md_reg1[XLEN-1];
  assign sgn2     = (md_op == 3'd1 || md_op == 3'd4 || md_op == 3'd6) && md_reg2[XLEN-1];
  assign mag1     = sgn1 ? -md_reg1 : md_reg1;
  assign mag2     = sgn2 ? -md_reg2 : md_reg2;
  assign div_zero = is_div && (md_reg2 == '0);
  assign div_ovf  = (md_op == 3'd4 || md_op == 3'd6) && (md_reg1 == MIN_NEG) && (md_reg2 == '1);

`ifdef MD_EARLY_OUT_EN
  // Zero product, or divisor larger than dividend: quotient 0, remainder is rs1 unchanged.
  assign early     = is_div ? (mag2 > mag1) : (md_reg1 == '0 || md_reg2 == '0);
  assign early_res = (is_div && md_op[1]) ? md_reg1 : '0;
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // md_op[1] picks remainder (REM/REMU) over quotient (DIV/DIVU).
  always_comb begin
    special_res = early_res;
    if (div_zero)
      special_res = md_op[1] ? md_reg1 : '1;
    else if (div_ovf)
      special_res = md_op[1] ? '0 : MIN_NEG;
  end

  logic [XLEN:0]     add_sum, shifted, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, prod;
  logic [XLEN-1:0]   quo, rem, calc_res;

  // Multiply: acc = {partial high, multiplier shifting out}. Divide: acc = {remainder, dividend->quotient}.
  assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_nx  = {add_sum, acc[XLEN-1:1]};
  assign shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff    = shifted - {1'b0, opd};
  assign div_nx  = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign acc_nx  = op_q[2] ? div_nx : mul_nx;

  assign prod = neg_a ? -acc_nx : acc_nx;
  assign quo  = neg_a ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
  assign rem  = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = prod[2*XLEN-1:XLEN];
    if (op_q[2])
      calc_res = op_q[1] ? rem : quo;
    else if (op_q == 3'd0)
      calc_res = prod[XLEN-1:0];
  end

  assign stall_req = RST && !flush && ((state == IDLE && md_start) || state == CALC);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opd       <= '0;
      op_q      <= '0;
      neg_a     <= 1'b0;
      neg_r     <= 1'b0;
      md_result <= '0;
      md_done   <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          md_done <= 1'b0;
          if (md_start) begin
            op_q  <= md_op;
            neg_a <= sgn1 ^ sgn2;
            neg_r <= sgn1;
            cnt   <= '0;
            if (div_zero || div_ovf || early) begin
              state     <= DONE;
              md_done   <= 1'b1;
              md_result <= special_res;
            end else begin
              state <= CALC;
              opd   <= is_div ? mag2 : mag1;
              acc   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state     <= DONE;
            md_done   <= 1'b1;
            md_result <= calc_res;
          end
        end
        DONE: begin
          // md_start is deliberately ignored here so the completing op cannot restart.
          state   <= IDLE;
          md_done <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          md_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed table, flush/reset sequences, randomized ops against an arithmetic model.
module tb_ex_muldiv;

  logic        CLK = 1'b0;
  logic        RST, md_start, flush;
  logic [2:0]  md_op;
  logic [31:0] md_reg1, md_reg2, md_result;
  logic        md_done, stall_req;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ex_muldiv #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .md_start(md_start), .md_op(md_op),
    .md_reg1(md_reg1), .md_reg2(md_reg2), .flush(flush),
    .md_result(md_result), .md_done(md_done), .stall_req(stall_req)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 0;
    case (op)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: p = (b == 0) ? -1 : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd3)
      return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic s1, s2;
    longint ma, mb;
    s1 = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    s2 = (op == 3'd1 || op == 3'd4 || op == 3'd6);
    ma = (s1 && $signed(a) < 0) ? -longint'($signed(a)) : longint'({32'h0, a});
    mb = (s2 && $signed(b) < 0) ? -longint'($signed(b)) : longint'({32'h0, b});
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MD_EARLY_OUT_EN
    if (op < 3'd4 && (a == 0 || b == 0)) return 1;
    if (op >= 3'd4 && mb > ma) return 1;
`endif
    if (ma < 0 || mb < 0) return -1;
    return 33;
  endfunction

  // Start in cycle 0, keep md_start high until md_done, then confirm a single-cycle strobe.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int low_stall;
    @(posedge CLK); #1;
    md_op = op; md_reg1 = a; md_reg2 = b; md_start = 1'b1;
    #1 check({tag, " stall c0"}, {31'b0, stall_req}, 32'd1);
    lat = -1;
    low_stall = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK); #1;
      if (md_done) begin
        lat = c;
        break;
      end
      if (!stall_req) low_stall++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, md_result, exp_res);
    check({tag, " stall in done"}, {31'b0, stall_req}, 32'd0);
    check({tag, " stall gaps"}, low_stall, 32'd0);
    @(posedge CLK); #1;
    md_start = 1'b0;
    #1 check({tag, " done strobe"}, {31'b0, md_done}, 32'd0);
    check({tag, " no retrigger"}, {31'b0, stall_req}, 32'd0);
  endtask

  vec_t tbl[14];

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;

    tbl[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    tbl[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    tbl[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    tbl[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    tbl[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tbl[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
    tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    tbl[12] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tbl[13] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};

    RST = 1'b0; md_start = 1'b0; flush = 1'b0;
    md_op = 3'd0; md_reg1 = '0; md_reg2 = '0;
    repeat (2) @(posedge CLK);
    #1 md_start = 1'b1;
    #1;
    check("reset md_done", {31'b0, md_done}, 32'd0);
    check("reset md_result", md_result, 32'd0);
    check("reset stall_req", {31'b0, stall_req}, 32'd0);
    md_start = 1'b0;
    RST = 1'b1;

    foreach (tbl[i])
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // Flush a DIVU in cycle 10, then a MUL starting in cycle 12 completes in cycle 45.
    @(posedge CLK); #1;
    md_op = 3'd5; md_reg1 = 32'd100; md_reg2 = 32'd7; md_start = 1'b1;
    repeat (10) @(posedge CLK);
    #1 flush = 1'b1;
    #1 check("flush stall", {31'b0, stall_req}, 32'd0);
    check("flush done", {31'b0, md_done}, 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0; md_start = 1'b0;
    #1 check("after flush done", {31'b0, md_done}, 32'd0);
    check("after flush stall", {31'b0, stall_req}, 32'd0);
    run_op("post-flush mul", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Reset asserted in cycle 5 of a MUL clears everything at once.
    @(posedge CLK); #1;
    md_op = 3'd0; md_reg1 = 32'h1234; md_reg2 = 32'h5678; md_start = 1'b1;
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("midreset md_done", {31'b0, md_done}, 32'd0);
    check("midreset md_result", md_result, 32'd0);
    check("midreset stall_req", {31'b0, stall_req}, 32'd0);
    md_start = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    run_op("post-reset mulhu", 3'd3, 32'h1234, 32'h5678, 32'd0, 33);

`ifdef MD_EARLY_OUT_EN
    run_op("early mul0", 3'd0, 32'd0, 32'h1234, 32'd0, 1);
    run_op("early divu", 3'd5, 32'd3, 32'd9, 32'd0, 1);
    run_op("early rem", 3'd6, 32'hFFFFFFFD, 32'd9, 32'hFFFFFFFD, 1);
`endif

    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = $urandom_range(0, 15);
      if (sel == 2) a = 32'd0;
      if (sel == 3) a = $urandom_range(0, 255);
      run_op($sformatf("rand%0d op%0d", k, op), op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
